awb_gain_calc: RTL and testbench
================================

AWB_GAIN_CALC -- requirements
Module: awb_gain_calc

Interface
REQ-001 The block SHALL have parameter COE_WIDTH, default 16, the width of one coefficient field in coe_o.
REQ-002 The block SHALL have parameter COE_FRACTION_WIDTH, default 10, the number of fraction bits of the unsigned Q3.10 gain (0x0400 = 1.000).
REQ-003 The block SHALL have parameter PIXEL_WIDTH, default 8, the width of one colour component.
REQ-004 The block SHALL have parameter ACC_WIDTH, default 32, the width of each per-channel frame accumulator.
REQ-005 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-006 rst_n  in  1  reset, synchronous and active-low.
REQ-007 di_i  in  PIXEL_WIDTH*3  pixel data: R at [PIXEL_WIDTH*0 +: PIXEL_WIDTH], G at [PIXEL_WIDTH*1 +: ...], B at [PIXEL_WIDTH*2 +: ...].
REQ-008 de_i  in  1  data enable; the pixel is valid when high.
REQ-009 hs_i  in  1  horizontal sync; SHALL be ignored except for forwarding nothing (no function).
REQ-010 vs_i  in  1  vertical sync, active-high; a rising edge marks the end of a frame.
REQ-011 en_i  in  1  gain-update enable.
REQ-012 coe_o  out  COE_WIDTH*3  gains R/G/B at field k [k*COE_WIDTH +: COE_WIDTH]; bits above bit 12 of each field SHALL be 0.
REQ-013 coe_vld_o  out  1  one-cycle pulse when coe_o has just been updated.
REQ-014 busy_o  out  1  high while a division is in progress.

Function
REQ-015 A pixel SHALL be accumulated when de_i=1 and vs_i=0: the R, G and B components are added to acc_r, acc_g and acc_b, and pix_cnt is incremented.
REQ-016 Each accumulator and pix_cnt SHALL saturate at all-ones and SHALL NOT wrap.
REQ-017 The frame-end event SHALL be detected when vs_i=1 is sampled with the previous sampled vs_i=0, at clock edge k.
REQ-018 At edge k the block SHALL snapshot the accumulators into sum_r/sum_g/sum_b, clear the accumulators and pix_cnt, and stop accumulating the pixel sampled at edge k.
REQ-019 The FSM SHALL have the states IDLE, DIV_R, DIV_B and UPDATE.
REQ-020 Transition IDLE->DIV_R SHALL occur at a frame end when en_i=1 and pix_cnt!=0; otherwise the FSM SHALL stay in IDLE and coe_o SHALL be unchanged.
REQ-021 In DIV_R, during edges k+1..k+13, the block SHALL compute coe_r = floor(sum_g*2^COE_FRACTION_WIDTH / sum_r) with a restoring divider producing 1 quotient bit per cycle, MSB first, 13 quotient bits.
REQ-022 In DIV_B, during edges k+14..k+26, the block SHALL compute coe_b from sum_b in the same manner.
REQ-023 In UPDATE, at edge k+27, coe_o SHALL be loaded as {coe_b, 0x0400, coe_r}, coe_vld_o SHALL be 1 for exactly that cycle, and the FSM SHALL return to IDLE.
REQ-024 The G gain SHALL always be 0x0400.
REQ-025 Saturation: if sum_g >= (divisor << 3) or the divisor = 0, the gain SHALL be 0x1FFF; this is checked before the division and the 13 cycles are still spent.
REQ-026 The quotient SHALL be truncated (no rounding).
REQ-027 busy_o SHALL be 1 in DIV_R and DIV_B, and 0 in IDLE and UPDATE.
REQ-028 A frame end while busy_o=1 SHALL clear the accumulators and discard that frame, and the running division SHALL be unaffected.
REQ-029 When en_i=0, coe_o SHALL hold its value, and any running division SHALL complete and update.
REQ-030 Accumulation SHALL continue during DIV_R and DIV_B.

Reset
REQ-031 When rst_n=0 at a clock edge, coe_o SHALL become {0x0400, 0x0400, 0x0400} in 16-bit fields, coe_vld_o=0, busy_o=0 and FSM=IDLE.
REQ-032 When rst_n=0 at a clock edge, the accumulators, pix_cnt, the snapshots and the sampled vs_i SHALL be cleared.
REQ-033 Reset asserted mid-division SHALL abort the division with no coe_vld_o pulse.

Verification
REQ-034 4 pixels R=64, G=128, B=32, then a vs_i rise at edge k -> coe_vld_o at k+27, coe_o R=0x0800, G=0x0400, B=0x1000.
REQ-035 Gray frame, all pixels 100 -> all three gains 0x0400; the busy_o high window SHALL be exactly 26 cycles.
REQ-036 1 pixel R=3, G=1, B=0 -> R gain 0x0155 (truncated), B gain 0x1FFF (zero divisor); 1 pixel R=8, G=128 -> R gain 0x1FFF (>=8.0).
REQ-037 Frame with no de_i, or en_i=0 at frame end -> no coe_vld_o, coe_o unchanged; a second vs_i rise during DIV_B -> only one update, and the next frame accumulates from zero.
REQ-038 rst_n=0 at k+10 mid-DIV_R -> no pulse, coe_o = 0x0400 x3, and the next valid frame yields a correct result.

Source files
------------

// File: rtl/awb_gain_calc.sv
// Auto-white-balance gain calculator: accumulates R/G/B per frame and, at each
// frame end, derives unsigned Q3.10 R and B gains relative to G with a serial divider.
module awb_gain_calc #(
  parameter int COE_WIDTH          = 16,
  parameter int COE_FRACTION_WIDTH = 10,
  parameter int PIXEL_WIDTH        = 8,
  parameter int ACC_WIDTH          = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PIXEL_WIDTH*3-1:0] di_i,
  input  logic                     de_i,
  input  logic                     hs_i,
  input  logic                     vs_i,
  input  logic                     en_i,
  output logic [COE_WIDTH*3-1:0]   coe_o,
  output logic                     coe_vld_o,
  output logic                     busy_o
);

  localparam int QW = COE_FRACTION_WIDTH + 3;
  localparam int SH = QW - COE_FRACTION_WIDTH;
  localparam logic [QW-1:0] GAIN_ONE = QW'(1 << COE_FRACTION_WIDTH);
  localparam logic [COE_WIDTH*3-1:0] COE_RST =
    {3{{(COE_WIDTH-QW){1'b0}}, GAIN_ONE}};

  typedef enum logic [1:0] {S_IDLE, S_DIV_R, S_DIV_B, S_UPDATE} state_t;

  state_t state_q, state_d;

  logic                  vs_q;
  logic [ACC_WIDTH-1:0]  acc_r_q, acc_g_q, acc_b_q, pix_cnt_q;
  logic [ACC_WIDTH-1:0]  sum_g_q, sum_b_q, div_q, rem_q;
  logic [QW-1:0]         nbits_q, quo_q, coe_r_q, coe_b_q;
  logic                  sat_q;
  logic [3:0]            cnt_q;
  logic [COE_WIDTH*3-1:0] coe_q;
  logic                  coe_vld_q;

  logic                  frame_end, go, last, div_act;
  logic [ACC_WIDTH:0]    trial_d, diff_d;
  logic                  ge_d;
  logic [ACC_WIDTH-1:0]  rem_d;
  logic [QW-1:0]         quo_d, result_d;
  logic                  unused_bits;

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] a,
                                                   input logic [PIXEL_WIDTH-1:0] b);
    logic [ACC_WIDTH:0] s;
    s = {1'b0, a} + {{(ACC_WIDTH+1-PIXEL_WIDTH){1'b0}}, b};
    return s[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : s[ACC_WIDTH-1:0];
  endfunction

  // Gain >= 8.0 (or divide by zero) cannot be represented in Q3.10.
  function automatic logic gain_sat(input logic [ACC_WIDTH-1:0] num,
                                    input logic [ACC_WIDTH-1:0] den);
    return {{SH{1'b0}}, num} >= {den, {SH{1'b0}}};
  endfunction

  assign frame_end = vs_i & ~vs_q;
  assign go        = (state_q == S_IDLE) & frame_end & en_i & (pix_cnt_q != '0);
  assign div_act   = (state_q == S_DIV_R) | (state_q == S_DIV_B);
  assign last      = (cnt_q == 4'(QW-1));

  // Quotient < 2^QW is guaranteed once saturation is excluded, so the partial
  // remainder starts at num >> SH and only the low QW dividend bits are shifted in.
  assign trial_d  = {rem_q, nbits_q[QW-1]};
  assign diff_d   = trial_d - {1'b0, div_q};
  assign ge_d     = trial_d >= {1'b0, div_q};
  assign rem_d    = ge_d ? diff_d[ACC_WIDTH-1:0] : trial_d[ACC_WIDTH-1:0];
  assign quo_d    = {quo_q[QW-2:0], ge_d};
  assign result_d = sat_q ? {QW{1'b1}} : quo_d;
  assign unused_bits = ^{hs_i, trial_d[ACC_WIDTH], diff_d[ACC_WIDTH]};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (go)   state_d = S_DIV_R;
      S_DIV_R:  if (last) state_d = S_DIV_B;
      S_DIV_B:  if (last) state_d = S_UPDATE;
      S_UPDATE:           state_d = S_IDLE;
      default:            state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o = div_act;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      acc_r_q   <= '0;
      acc_g_q   <= '0;
      acc_b_q   <= '0;
      pix_cnt_q <= '0;
    end else begin
      vs_q <= vs_i;
      if (frame_end) begin
        acc_r_q   <= '0;
        acc_g_q   <= '0;
        acc_b_q   <= '0;
        pix_cnt_q <= '0;
      end else if (de_i && !vs_i) begin
        acc_r_q   <= sat_add(acc_r_q, di_i[PIXEL_WIDTH*0 +: PIXEL_WIDTH]);
        acc_g_q   <= sat_add(acc_g_q, di_i[PIXEL_WIDTH*1 +: PIXEL_WIDTH]);
        acc_b_q   <= sat_add(acc_b_q, di_i[PIXEL_WIDTH*2 +: PIXEL_WIDTH]);
        pix_cnt_q <= sat_add(pix_cnt_q, PIXEL_WIDTH'(1));
      end
    end
  end

  // Snapshots are taken only when a division starts, so frames ending while busy
  // cannot disturb the operands still needed for the B gain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_g_q <= '0;
      sum_b_q <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      nbits_q <= '0;
      quo_q   <= '0;
      sat_q   <= 1'b0;
      cnt_q   <= '0;
      coe_r_q <= '0;
      coe_b_q <= '0;
    end else begin
      cnt_q <= (div_act && !last) ? cnt_q + 4'd1 : 4'd0;
      if (go) begin
        sum_g_q <= acc_g_q;
        sum_b_q <= acc_b_q;
        div_q   <= acc_r_q;
        rem_q   <= acc_g_q >> SH;
        nbits_q <= {acc_g_q[SH-1:0], {COE_FRACTION_WIDTH{1'b0}}};
        quo_q   <= '0;
        sat_q   <= gain_sat(acc_g_q, acc_r_q);
      end else if (div_act) begin
        if (last && state_q == S_DIV_R) begin
          coe_r_q <= result_d;
          div_q   <= sum_b_q;
          rem_q   <= sum_g_q >> SH;
          nbits_q <= {sum_g_q[SH-1:0], {COE_FRACTION_WIDTH{1'b0}}};
          quo_q   <= '0;
          sat_q   <= gain_sat(sum_g_q, sum_b_q);
        end else if (last) begin
          coe_b_q <= result_d;
        end else begin
          rem_q   <= rem_d;
          nbits_q <= nbits_q << 1;
          quo_q   <= quo_d;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      coe_q     <= COE_RST;
      coe_vld_q <= 1'b0;
    end else begin
      coe_vld_q <= (state_q == S_UPDATE);
      if (state_q == S_UPDATE)
        coe_q <= {{(COE_WIDTH-QW){1'b0}}, coe_b_q,
                  {(COE_WIDTH-QW){1'b0}}, GAIN_ONE,
                  {(COE_WIDTH-QW){1'b0}}, coe_r_q};
    end
  end

  assign coe_o     = coe_q;
  assign coe_vld_o = coe_vld_q;

endmodule

// File: tb/tb_awb_gain_calc.sv
// Directed bench for awb_gain_calc: hand-computed gains, latency, busy window,
// discarded frames and mid-division reset.
module tb_awb_gain_calc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] di_i;
  logic        de_i, hs_i, vs_i, en_i;
  logic [47:0] coe_o;
  logic        coe_vld_o, busy_o;

  int n_checks = 0;
  int n_errs   = 0;

  localparam logic [47:0] COE_RST = 48'h0400_0400_0400;

  awb_gain_calc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .di_i      (di_i),
    .de_i      (de_i),
    .hs_i      (hs_i),
    .vs_i      (vs_i),
    .en_i      (en_i),
    .coe_o     (coe_o),
    .coe_vld_o (coe_vld_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    di_i = {b, g, r};
    de_i = 1'b1;
    tick();
    de_i = 1'b0;
  endtask

  // Raise vs for one edge (edge k), then observe max cycles after it.
  task automatic frame_end_wait(input int max, input bit drop_en,
                                output int lat, output int busy_cnt, output int vld_cnt);
    lat = 0; busy_cnt = 0; vld_cnt = 0;
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    if (drop_en) en_i = 1'b0;
    if (busy_o) busy_cnt++;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (busy_o) busy_cnt++;
      if (coe_vld_o) begin
        vld_cnt++;
        if (lat == 0) lat = i;
      end
    end
  endtask

  int lat, bcnt, vcnt;

  initial begin
    rst_n = 1'b0; di_i = '0; de_i = 0; hs_i = 0; vs_i = 0; en_i = 1;
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_coe", coe_o, COE_RST);
    chk("rst_vld", coe_vld_o, 0);
    chk("rst_busy", busy_o, 0);

    // 4 pixels 64/128/32: R gain 2.0, B gain 4.0
    repeat (4) push_pix(8'd64, 8'd128, 8'd32);
    frame_end_wait(30, 0, lat, bcnt, vcnt);
    chk("basic_lat", lat, 27);
    chk("basic_vld_cnt", vcnt, 1);
    chk("basic_busy", bcnt, 26);
    chk("basic_coe", coe_o, 48'h1000_0400_0800);

    // gray frame; en_i dropped right after start must not stop the update
    repeat (5) push_pix(8'd100, 8'd100, 8'd100);
    frame_end_wait(30, 1, lat, bcnt, vcnt);
    en_i = 1'b1;
    chk("gray_lat", lat, 27);
    chk("gray_busy", bcnt, 26);
    chk("gray_coe", coe_o, 48'h0400_0400_0400);

    // 1024/3 truncated, zero B divisor saturates
    push_pix(8'd3, 8'd1, 8'd0);
    frame_end_wait(30, 0, lat, bcnt, vcnt);
    chk("trunc_vld_cnt", vcnt, 1);
    chk("trunc_coe", coe_o, 48'h1FFF_0400_0155);

    // G/R = 16 >= 8.0 saturates
    push_pix(8'd8, 8'd128, 8'd128);
    frame_end_wait(30, 0, lat, bcnt, vcnt);
    chk("sat_coe", coe_o, 48'h0400_0400_1FFF);

    // empty frame: no update
    frame_end_wait(35, 0, lat, bcnt, vcnt);
    chk("empty_vld_cnt", vcnt, 0);
    chk("empty_busy", bcnt, 0);
    chk("empty_coe", coe_o, 48'h0400_0400_1FFF);

    // en_i low at frame end: no update
    en_i = 1'b0;
    push_pix(8'd50, 8'd50, 8'd50);
    frame_end_wait(35, 0, lat, bcnt, vcnt);
    en_i = 1'b1;
    chk("dis_vld_cnt", vcnt, 0);
    chk("dis_coe", coe_o, 48'h0400_0400_1FFF);

    // second vs rise during DIV_B is discarded with its pixels
    repeat (4) push_pix(8'd64, 8'd128, 8'd32);
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    vcnt = 0;
    for (int i = 1; i <= 30; i++) begin
      de_i = (i >= 2 && i <= 10);
      di_i = {8'd1, 8'd200, 8'd1};
      vs_i = (i == 16);
      tick();
      if (i == 16) chk("busy_at_k16", busy_o, 1);
      if (coe_vld_o) vcnt++;
    end
    de_i = 1'b0; vs_i = 1'b0;
    chk("dbl_vld_cnt", vcnt, 1);
    chk("dbl_coe", coe_o, 48'h1000_0400_0800);
    repeat (2) push_pix(8'd128, 8'd128, 8'd64);
    frame_end_wait(30, 0, lat, bcnt, vcnt);
    chk("after_dbl_coe", coe_o, 48'h0800_0400_0400);

    // reset at edge k+10 aborts the division
    repeat (4) push_pix(8'd64, 8'd128, 8'd32);
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    repeat (9) tick();
    chk("pre_rst_busy", busy_o, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_coe", coe_o, COE_RST);
    vcnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (coe_vld_o) vcnt++;
    end
    chk("mid_rst_vld_cnt", vcnt, 0);
    chk("mid_rst_coe_hold", coe_o, COE_RST);
    repeat (4) push_pix(8'd64, 8'd128, 8'd32);
    frame_end_wait(30, 0, lat, bcnt, vcnt);
    chk("post_rst_lat", lat, 27);
    chk("post_rst_coe", coe_o, 48'h1000_0400_0800);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
